// File: rtl/regfile_seq_pkg.sv
// Shared opcode and state definitions for the register-file sequencer.
package regfile_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_LDI = 3'd6;
    localparam logic [OP_W-1:0] OP_MOV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational 8-bit ALU; carryValid marks ops that update the carry flag.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DataBusWidth = 8
) (
    input  logic [OP_W-1:0]         op,
    input  logic [DataBusWidth-1:0] opA,
    input  logic [DataBusWidth-1:0] opB,
    input  logic [DataBusWidth-1:0] imm,
    output logic [DataBusWidth-1:0] result,
    output logic                    carry,
    output logic                    carryValid
);

    logic [DataBusWidth:0] wide;

    always_comb begin
        wide       = '0;
        result     = '0;
        carry      = 1'b0;
        carryValid = 1'b0;
        case (op)
            OP_ADD: begin
                wide       = {1'b0, opA} + {1'b0, opB};
                result     = wide[DataBusWidth-1:0];
                carry      = wide[DataBusWidth];
                carryValid = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                wide       = {1'b0, opA} - {1'b0, opB};
                result     = wide[DataBusWidth-1:0];
                carry      = wide[DataBusWidth];
                carryValid = 1'b1;
            end
            OP_AND:  result = opA & opB;
            OP_OR:   result = opA | opB;
            OP_XOR:  result = opA ^ opB;
            OP_LDI:  result = imm;
            OP_MOV:  result = opA;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one decoded command through read, execute and register-file write-back.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned AddrBusWidth = 2,
    parameter int unsigned DataBusWidth = 8
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic [OP_W-1:0]         cmdOp,
    input  logic [AddrBusWidth-1:0] cmdRd,
    input  logic [AddrBusWidth-1:0] cmdRs1,
    input  logic [AddrBusWidth-1:0] cmdRs2,
    input  logic [DataBusWidth-1:0] cmdImm,
    output logic [AddrBusWidth-1:0] rfA1,
    output logic [AddrBusWidth-1:0] rfA2,
    input  logic [DataBusWidth-1:0] rfOut1,
    input  logic [DataBusWidth-1:0] rfOut2,
    output logic [AddrBusWidth-1:0] rfAWrite,
    output logic [DataBusWidth-1:0] rfDataIn,
    output logic                    rfLoad,
    output logic                    rspValid,
    output logic [DataBusWidth-1:0] rspData,
    output logic                    flagZ,
    output logic                    flagC
);

    state_e                  state_q, state_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [AddrBusWidth-1:0] rd_q, rd_d;
    logic [DataBusWidth-1:0] imm_q, imm_d;
    logic [DataBusWidth-1:0] opa_q, opa_d;
    logic [DataBusWidth-1:0] opb_q, opb_d;
    logic [DataBusWidth-1:0] result_q, result_d;
    logic                    carry_q, carry_d;
    logic                    carry_valid_q, carry_valid_d;

    logic [AddrBusWidth-1:0] rf_a1_d, rf_a2_d, rf_awrite_d;
    logic [DataBusWidth-1:0] rf_data_in_d, rsp_data_d;
    logic                    rf_load_d, rsp_valid_d, flag_z_d, flag_c_d;

    logic [DataBusWidth-1:0] alu_result;
    logic                    alu_carry, alu_carry_valid;

    regfile_seq_alu #(
        .DataBusWidth(DataBusWidth)
    ) u_alu (
        .op        (op_q),
        .opA       (opa_q),
        .opB       (opb_q),
        .imm       (imm_q),
        .result    (alu_result),
        .carry     (alu_carry),
        .carryValid(alu_carry_valid)
    );

    assign cmdReady = (state_q == ST_IDLE);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        result_d      = result_q;
        carry_d       = carry_q;
        carry_valid_d = carry_valid_q;
        rf_a1_d       = rfA1;
        rf_a2_d       = rfA2;
        rf_awrite_d   = rfAWrite;
        rf_data_in_d  = rfDataIn;
        rsp_data_d    = rspData;
        flag_z_d      = flagZ;
        flag_c_d      = flagC;
        rf_load_d     = 1'b0;
        rsp_valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmdValid) begin
                    op_d    = cmdOp;
                    rd_d    = cmdRd;
                    imm_d   = cmdImm;
                    rf_a1_d = cmdRs1;
                    rf_a2_d = cmdRs2;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                opa_d   = rfOut1;
                opb_d   = rfOut2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d      = alu_result;
                carry_d       = alu_carry;
                carry_valid_d = alu_carry_valid;
                // NOP completes here: no write-back and flags untouched.
                if (op_q == OP_NOP) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                rf_load_d    = 1'b1;
                rf_awrite_d  = rd_q;
                rf_data_in_d = result_q;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = result_q;
                flag_z_d     = (result_q == '0);
                if (carry_valid_q) begin
                    flag_c_d = carry_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            carry_valid_q <= 1'b0;
            rfA1          <= '0;
            rfA2          <= '0;
            rfAWrite      <= '0;
            rfDataIn      <= '0;
            rfLoad        <= 1'b0;
            rspValid      <= 1'b0;
            rspData       <= '0;
            flagZ         <= 1'b0;
            flagC         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            carry_valid_q <= carry_valid_d;
            rfA1          <= rf_a1_d;
            rfA2          <= rf_a2_d;
            rfAWrite      <= rf_awrite_d;
            rfDataIn      <= rf_data_in_d;
            rfLoad        <= rf_load_d;
            rspValid      <= rsp_valid_d;
            rspData       <= rsp_data_d;
            flagZ         <= flag_z_d;
            flagC         <= flag_c_d;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 4x8 register file.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic       clk;
    logic       nRst;
    logic       cmdValid;
    logic       cmdReady;
    logic [2:0] cmdOp;
    logic [1:0] cmdRd, cmdRs1, cmdRs2;
    logic [7:0] cmdImm;
    logic [1:0] rfA1, rfA2, rfAWrite;
    logic [7:0] rfOut1, rfOut2, rfDataIn, rspData;
    logic       rfLoad, rspValid, flagZ, flagC;

    logic [7:0] rf [4];
    logic       rf_clear;

    int total  = 0;
    int passed = 0;

    regfile_sequencer #(
        .AddrBusWidth(2),
        .DataBusWidth(8)
    ) dut (
        .clk     (clk),
        .nRst    (nRst),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdOp   (cmdOp),
        .cmdRd   (cmdRd),
        .cmdRs1  (cmdRs1),
        .cmdRs2  (cmdRs2),
        .cmdImm  (cmdImm),
        .rfA1    (rfA1),
        .rfA2    (rfA2),
        .rfOut1  (rfOut1),
        .rfOut2  (rfOut2),
        .rfAWrite(rfAWrite),
        .rfDataIn(rfDataIn),
        .rfLoad  (rfLoad),
        .rspValid(rspValid),
        .rspData (rspData),
        .flagZ   (flagZ),
        .flagC   (flagC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (rfLoad) begin
            rf[rfAWrite] <= rfDataIn;
        end
    end

    assign rfOut1 = rf[rfA1];
    assign rfOut2 = rf[rfA2];

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm);
        cmdOp    = op;
        cmdRd    = rd;
        cmdRs1   = rs1;
        cmdRs2   = rs2;
        cmdImm   = imm;
        cmdValid = 1'b1;
        @(posedge clk);
        #1 cmdValid = 1'b0;
    endtask

    // Negedges until rspValid is seen (0 on timeout), plus cmdReady-low samples.
    task automatic wait_rsp(output int cycles, output int lows);
        cycles = 0;
        lows   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!cmdReady) lows++;
            if (rspValid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        nRst     = 1'b0;
        rf_clear = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = OP_NOP;
        cmdRd    = '0;
        cmdRs1   = '0;
        cmdRs2   = '0;
        cmdImm   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRst     = 1'b1;
        rf_clear = 1'b0;
        total++;
        if (cmdReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmdReady);
        else passed++;
        total++;
        if ({rfA1, rfA2, rfAWrite, rfDataIn, rspData, rfLoad, rspValid, flagZ, flagC} !== 33'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {rfA1, rfA2, rfAWrite, rfDataIn, rspData, rfLoad, rspValid, flagZ, flagC});
        else passed++;
    endtask

    task automatic test_ldi;
        int cyc, lows;
        send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h56);
        wait_rsp(cyc, lows);
        total++;
        if (cyc != 4) $display("FAIL ldi_latency: got %0d want 4", cyc);
        else passed++;
        total++;
        if ({rfLoad, rfAWrite, rfDataIn} !== {1'b1, 2'd1, 8'h56})
            $display("FAIL ldi_write: got load=%b addr=%0d data=%h want 1/1/56",
                     rfLoad, rfAWrite, rfDataIn);
        else passed++;
        total++;
        if ({rspData, flagZ, flagC} !== {8'h56, 2'b00})
            $display("FAIL ldi_rsp: got data=%h z=%b c=%b want 56/0/0", rspData, flagZ, flagC);
        else passed++;
        @(negedge clk);
        total++;
        if ({rfLoad, rspValid} !== 2'b00)
            $display("FAIL ldi_pulse: got load=%b rsp=%b want 0/0", rfLoad, rspValid);
        else passed++;
        total++;
        if (rf[1] !== 8'h56) $display("FAIL ldi_rf: got %h want 56", rf[1]);
        else passed++;
    endtask

    task automatic test_add;
        int cyc, lows;
        send(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hF0);
        wait_rsp(cyc, lows);
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h20);
        wait_rsp(cyc, lows);
        send(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
        @(negedge clk);
        total++;
        if ({rfA1, rfA2} !== {2'd1, 2'd2})
            $display("FAIL add_read_addr: got a1=%0d a2=%0d want 1/2", rfA1, rfA2);
        else passed++;
        wait_rsp(cyc, lows);
        total++;
        if ({rfAWrite, rfDataIn} !== {2'd3, 8'h10})
            $display("FAIL add_write: got addr=%0d data=%h want 3/10", rfAWrite, rfDataIn);
        else passed++;
        total++;
        if ({flagZ, flagC} !== 2'b01)
            $display("FAIL add_flags: got z=%b c=%b want 0/1", flagZ, flagC);
        else passed++;
        @(negedge clk);
        total++;
        if (rf[3] !== 8'h10) $display("FAIL add_rf: got %h want 10", rf[3]);
        else passed++;
    endtask

    task automatic test_sub;
        int cyc, lows;
        send(OP_SUB, 2'd2, 2'd2, 2'd2, 8'h00);
        wait_rsp(cyc, lows);
        total++;
        if ({rfDataIn, flagZ, flagC} !== {8'h00, 2'b10})
            $display("FAIL sub_zero: got data=%h z=%b c=%b want 00/1/0", rfDataIn, flagZ, flagC);
        else passed++;
        send(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h01);
        wait_rsp(cyc, lows);
        send(OP_SUB, 2'd3, 2'd0, 2'd1, 8'h00);
        wait_rsp(cyc, lows);
        total++;
        if ({rfDataIn, flagZ, flagC} !== {8'h11, 2'b01})
            $display("FAIL sub_borrow: got data=%h z=%b c=%b want 11/0/1", rfDataIn, flagZ, flagC);
        else passed++;
        @(negedge clk);
        total++;
        if ({rf[2], rf[3]} !== {8'h00, 8'h11})
            $display("FAIL sub_rf: got r2=%h r3=%h want 00/11", rf[2], rf[3]);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int cyc, lows;
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h7F);
        wait_rsp(cyc, lows);
        total++;
        if (lows != 3) $display("FAIL b2b_ready_low_ldi: got %0d want 3", lows);
        else passed++;
        total++;
        if (cmdReady !== 1'b1) $display("FAIL b2b_ready_at_rsp: got %b want 1", cmdReady);
        else passed++;
        send(OP_MOV, 2'd0, 2'd2, 2'd0, 8'h00);
        wait_rsp(cyc, lows);
        total++;
        if (cyc != 4 || lows != 3)
            $display("FAIL b2b_mov_timing: got cyc=%0d lows=%0d want 4/3", cyc, lows);
        else passed++;
        total++;
        if ({rfAWrite, rfDataIn} !== {2'd0, 8'h7F})
            $display("FAIL b2b_raw: got addr=%0d data=%h want 0/7f", rfAWrite, rfDataIn);
        else passed++;
        total++;
        if ({flagZ, flagC} !== 2'b01)
            $display("FAIL b2b_mov_flags: got z=%b c=%b want 0/1", flagZ, flagC);
        else passed++;
        @(negedge clk);
        total++;
        if (rf[0] !== 8'h7F) $display("FAIL b2b_rf: got %h want 7f", rf[0]);
        else passed++;
    endtask

    task automatic test_busy_ignore;
        int loads, rsps, cyc, lows;
        logic [7:0] data;
        loads = 0;
        rsps  = 0;
        data  = 8'h00;
        // r0=7f, r3=11 -> 90
        cmdOp    = OP_ADD;
        cmdRd    = 2'd1;
        cmdRs1   = 2'd0;
        cmdRs2   = 2'd3;
        cmdImm   = 8'h00;
        cmdValid = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (rfLoad) begin
                loads++;
                data = rfDataIn;
            end
            if (rspValid) rsps++;
            if (j == 1) begin
                cmdOp  = OP_LDI;
                cmdRd  = 2'd2;
                cmdImm = 8'hEE;
            end else if (j == 2) begin
                cmdOp = OP_SUB;
            end else begin
                cmdValid = 1'b0;
            end
        end
        total++;
        if (loads != 1 || rsps != 1)
            $display("FAIL busy_pulses: got loads=%0d rsps=%0d want 1/1", loads, rsps);
        else passed++;
        total++;
        if (data !== 8'h90) $display("FAIL busy_data: got %h want 90", data);
        else passed++;
        total++;
        if ({rf[1], rf[2]} !== {8'h90, 8'h7F})
            $display("FAIL busy_rf: got r1=%h r2=%h want 90/7f", rf[1], rf[2]);
        else passed++;
        total++;
        if ({flagZ, flagC} !== 2'b00)
            $display("FAIL busy_flags: got z=%b c=%b want 0/0", flagZ, flagC);
        else passed++;

        // Set C=1, then Z=1, so NOP has non-trivial flags to preserve.
        send(OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00);
        wait_rsp(cyc, lows);
        send(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h00);
        wait_rsp(cyc, lows);
        total++;
        if ({flagZ, flagC} !== 2'b11)
            $display("FAIL ldi_keeps_c: got z=%b c=%b want 1/1", flagZ, flagC);
        else passed++;
    endtask

    task automatic test_nop;
        int loads, rsp_at;
        logic [7:0] data;
        loads  = 0;
        rsp_at = 0;
        data   = 8'hFF;
        send(OP_NOP, 2'd3, 2'd1, 2'd2, 8'hAA);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (rfLoad) loads++;
            if (rspValid && rsp_at == 0) begin
                rsp_at = j;
                data   = rspData;
            end
        end
        total++;
        if (rsp_at != 3) $display("FAIL nop_latency: got %0d want 3", rsp_at);
        else passed++;
        total++;
        if (loads != 0) $display("FAIL nop_no_write: got %0d loads want 0", loads);
        else passed++;
        total++;
        if (data !== 8'h00) $display("FAIL nop_rsp_data: got %h want 00", data);
        else passed++;
        total++;
        if ({flagZ, flagC} !== 2'b11)
            $display("FAIL nop_flags: got z=%b c=%b want 1/1", flagZ, flagC);
        else passed++;
        total++;
        if ({rf[0], rf[2], rf[3]} !== {8'h00, 8'h20, 8'h11})
            $display("FAIL nop_rf: got r0=%h r2=%h r3=%h want 00/20/11", rf[0], rf[2], rf[3]);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int loads, rsps, cyc, lows;
        loads = 0;
        rsps  = 0;
        send(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        total++;
        if (cmdReady !== 1'b1) $display("FAIL midrst_ready: got %b want 1", cmdReady);
        else passed++;
        total++;
        if ({rfA1, rfA2, rfAWrite, rfDataIn, rspData, rfLoad, rspValid, flagZ, flagC} !== 33'd0)
            $display("FAIL midrst_outputs: got %h want 0",
                     {rfA1, rfA2, rfAWrite, rfDataIn, rspData, rfLoad, rspValid, flagZ, flagC});
        else passed++;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (rfLoad) loads++;
            if (rspValid) rsps++;
        end
        total++;
        if (loads != 0 || rsps != 0)
            $display("FAIL midrst_discard: got loads=%0d rsps=%0d want 0/0", loads, rsps);
        else passed++;
        total++;
        if (rf[3] !== 8'h11) $display("FAIL midrst_rf: got %h want 11", rf[3]);
        else passed++;
        send(OP_LDI, 2'd3, 2'd0, 2'd0, 8'hA5);
        wait_rsp(cyc, lows);
        total++;
        if (cyc != 4 || rfDataIn !== 8'hA5 || rfAWrite !== 2'd3)
            $display("FAIL midrst_recover: got cyc=%0d data=%h addr=%0d want 4/a5/3",
                     cyc, rfDataIn, rfAWrite);
        else passed++;
        @(negedge clk);
        total++;
        if (rf[3] !== 8'hA5) $display("FAIL midrst_recover_rf: got %h want a5", rf[3]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add();
        test_sub();
        test_back_to_back();
        test_busy_ignore();
        test_nop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
